// File: rtl/tug_scorer.sv
// Tug-of-war game state: moves a one-hot rope position on player pushes,
// then runs a tick-paced win flash before re-centring the rope.
module tug_scorer #(
  parameter int START_POS     = 3,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       leftp,
  input  logic       rightp,
  input  logic       tick,
  output logic [1:0] leds_ctrl,
  output logic [6:0] score,
  output logic [1:0] winner
);

  localparam logic [6:0] CENTRE    = 7'b1 << START_POS;
  localparam logic [3:0] LAST_TICK = 4'(FLASH_TOGGLES - 1);

  localparam logic [1:0] LEDS_SCORE = 2'b00;
  localparam logic [1:0] LEDS_ON    = 2'b01;
  localparam logic [1:0] LEDS_OFF   = 2'b10;

  typedef enum logic {PLAY, WIN} state_t;

  state_t     state_q, state_d;
  logic [6:0] score_q, score_d;
  logic [1:0] leds_q, leds_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    leds_d   = leds_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;
    case (state_q)
      PLAY: begin
        // A win needs a push while already sitting on the end LED.
        if (leftp && !rightp) begin
          if (score_q[6]) begin
            state_d  = WIN;
            winner_d = 2'b10;
            leds_d   = LEDS_ON;
            cnt_d    = '0;
          end else begin
            score_d = {score_q[5:0], 1'b0};
          end
        end else if (rightp && !leftp) begin
          if (score_q[0]) begin
            state_d  = WIN;
            winner_d = 2'b01;
            leds_d   = LEDS_ON;
            cnt_d    = '0;
          end else begin
            score_d = {1'b0, score_q[6:1]};
          end
        end
      end
      WIN: begin
        if (tick) begin
          if (cnt_q == LAST_TICK) begin
            state_d  = PLAY;
            score_d  = CENTRE;
            leds_d   = LEDS_SCORE;
            winner_d = 2'b00;
            cnt_d    = '0;
          end else begin
            cnt_d  = cnt_q + 4'd1;
            leds_d = (leds_q == LEDS_ON) ? LEDS_OFF : LEDS_ON;
          end
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PLAY;
      score_q  <= CENTRE;
      leds_q   <= LEDS_SCORE;
      winner_q <= 2'b00;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      leds_q   <= leds_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign score     = score_q;
  assign leds_ctrl = leds_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_tug_scorer.sv
// Bench for tug_scorer: directed game scenarios followed by random pushes/ticks,
// all checked against an integer-position game model.
module tb_tug_scorer;

  localparam int SP = 3;
  localparam int FT = 6;

  logic       clk = 1'b0;
  logic       rst, leftp, rightp, tick;
  logic [1:0] leds_ctrl, winner;
  logic [6:0] score;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: rope position as a bit index, flash progress as a tick count
  int         m_pos;
  bit         m_win;
  int         m_fl;
  logic [1:0] m_wnr;

  tug_scorer #(.START_POS(SP), .FLASH_TOGGLES(FT)) dut (
    .clk(clk), .rst(rst), .leftp(leftp), .rightp(rightp), .tick(tick),
    .leds_ctrl(leds_ctrl), .score(score), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_score();
    logic [6:0] one;
    one = 7'b1;
    return one << m_pos;
  endfunction

  function automatic logic [1:0] exp_leds();
    if (!m_win) return 2'b00;
    return (m_fl % 2 == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_reset();
    m_pos = SP; m_win = 0; m_fl = 0; m_wnr = 2'b00;
  endtask

  task automatic model_step(input bit l, input bit r, input bit t);
    if (!m_win) begin
      if (l && !r) begin
        if (m_pos == 6) begin m_win = 1; m_wnr = 2'b10; m_fl = 0; end
        else m_pos++;
      end else if (r && !l) begin
        if (m_pos == 0) begin m_win = 1; m_wnr = 2'b01; m_fl = 0; end
        else m_pos--;
      end
    end else if (t) begin
      if (m_fl == FT - 1) model_reset();
      else m_fl++;
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".score"},  32'(score),     32'(exp_score()));
    chk({tag, ".leds"},   32'(leds_ctrl), 32'(exp_leds()));
    chk({tag, ".winner"}, 32'(winner),    32'(m_wnr));
  endtask

  // called at a negedge; drives one cycle of inputs and checks after the edge
  task automatic step(input bit l, input bit r, input bit t, input string tag);
    leftp = l; rightp = r; tick = t;
    @(posedge clk);
    model_step(l, r, t);
    #1;
    chk_outs(tag);
    @(negedge clk);
    leftp = 0; rightp = 0; tick = 0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, tag);
  endtask

  always @(negedge clk)
    if (!rst) chk("onehot", 32'($onehot(score)), 32'd1);

  initial begin
    rst = 1; leftp = 0; rightp = 0; tick = 0;
    model_reset();
    #2;
    chk_outs("rst0");
    @(negedge clk); @(negedge clk);
    rst = 0;

    // quiet after reset, including ignored ticks in PLAY
    idle(20, "idle");
    step(0, 0, 1, "play_tick");

    // march to the left end, then win
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, "left_mv");
      idle(4, "left_gap");
    end
    chk("at_left_end", 32'(score), 32'h40);
    step(1, 0, 0, "left_win");
    chk("left_winner", 32'(winner), 32'h2);
    for (int k = 0; k < FT; k++) begin
      step(0, k % 2, 1, "flash_l");
      idle(2, "flash_gap");
    end
    chk("recentre", 32'(score), 32'h08);

    // tie at centre
    step(1, 1, 0, "tie");

    // win to the right with a tick on the winning push
    for (int k = 0; k < 3; k++) step(0, 1, 0, "right_mv");
    step(0, 1, 1, "right_win_tick");
    chk("right_winner", 32'(winner), 32'h1);
    for (int k = 0; k < FT - 1; k++) step(1, 1, 1, "flash_r");
    chk("still_win", 32'(winner), 32'h1);
    step(0, 0, 1, "flash_r_exit");
    chk("right_exit", 32'(winner), 32'h0);

    // async reset mid-flash
    for (int k = 0; k < 3; k++) step(0, 1, 0, "r_mv2");
    step(0, 1, 0, "r_win2");
    step(0, 0, 1, "r_fl1");
    step(0, 0, 1, "r_fl2");
    #2 rst = 1;
    #1;
    model_reset();
    chk_outs("async_rst");
    @(negedge clk);
    rst = 0;
    step(1, 0, 0, "post_rst");
    idle(2, "post_rst_idle");

    // random play
    for (int i = 0; i < 3000; i++) begin
      bit l, r, t;
      l = ($urandom_range(0, 99) < 35);
      r = ($urandom_range(0, 99) < 35);
      t = ($urandom_range(0, 99) < 30);
      step(l, r, t, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/tug_scorer.md
Name: tug_scorer

Overview:
Game-state core of the tug-of-war design. It consumes single-cycle button pulses from the debouncers and a slow tick. It produces the rope position (score) and the display-mode select (leds_ctrl) that the LED mux directly downstream turns into the 7-LED pattern. It also runs the win-flash sequence and re-centres the rope afterwards.

Parameters:
START_POS, 3, bit index of the centre LED loaded on reset and after every win (range 0..6)
FLASH_TOGGLES, 6, number of tick periods spent in win-flash before play resumes (range 1..15; even values end on "off")

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
leftp  input  1  left-player push, one-cycle pulse (already debounced and edge-detected)
rightp  input  1  right-player push, one-cycle pulse
tick  input  1  one-cycle enable at flash rate (about 4 Hz), used only in WIN
leds_ctrl  output  2  display mode to the LED mux: 00 show score, 01 all on, 10 all off, 11 unused (never driven)
score  output  7  one-hot rope position; bit 6 = left end, bit 0 = right end
winner  output  2  10 left won, 01 right won, 00 no winner; held for the whole WIN state

Behaviour:
- Reset (async, immediate): state=PLAY, score=1<<START_POS (7'b0001000 by default), leds_ctrl=00, winner=00, flash count=0.
- All outputs are registered. An event sampled at edge n is visible after edge n, so latency is 1 cycle.
- Two states: PLAY and WIN.
- PLAY, leftp=1 and rightp=0:
  - score[6]=0: score shifts left by 1.
  - score[6]=1: enter WIN with winner=10. score holds 7'b1000000, leds_ctrl=01, count=0.
- PLAY, rightp=1 and leftp=0:
  - score[0]=0: score shifts right by 1.
  - score[0]=1: enter WIN with winner=01. score holds 7'b0000001, leds_ctrl=01, count=0.
- PLAY, leftp=1 and rightp=1 in the same cycle: tie, no change.
- PLAY, no push: hold. tick is ignored in PLAY.
- A win therefore needs a push while already at the end LED. Reaching bit 6 or bit 0 alone is not a win.
- WIN: leftp and rightp are ignored entirely (no queuing).
- WIN, on each tick:
  - count < FLASH_TOGGLES-1: count++ and leds_ctrl toggles 01<->10.
  - count = FLASH_TOGGLES-1: return to PLAY with score=1<<START_POS, leds_ctrl=00, winner=00, count=0.
- Tick in the same cycle as the winning push: the transition to WIN wins, and that tick is not counted.
- Score invariant: score is always exactly one-hot. Any non-one-hot value is a design error and is flagged by a bench assertion.
- Reset asserted mid-WIN or mid-shift: immediate return to reset values. No partial flash resumes after rst deasserts.
- leds_ctrl never takes value 11.

Test Plan:
- Reset with no stimulus for 20 cycles -> score=0001000, leds_ctrl=00, winner=00, constant throughout.
- 3 leftp pulses, each 1 cycle and 5 cycles apart -> score reads 0010000, 0100000, 1000000, each one cycle after its pulse; leds_ctrl stays 00, winner stays 00.
- A 4th leftp at 1000000 -> next cycle winner=10, leds_ctrl=01, score=1000000. Then 6 ticks -> leds_ctrl goes 10,01,10,01,10, and after the 6th tick score=0001000, leds_ctrl=00, winner=00.
- leftp and rightp in the same cycle at centre -> score unchanged. rightp pulses issued during WIN -> no effect on score or on the flash sequence.
- 4 rightp from centre, with a tick coincident with the 4th (winning) push -> winner=01 and count=0. Exactly 6 further ticks are still needed to exit WIN.
- rst pulsed asynchronously (mid-cycle) after the 2nd flash tick -> outputs reach reset values before the next clk edge, and play resumes from centre.
